// File: rtl/inst_fetcher.sv
// Instruction fetch stage: samples the predicted PC, fetches one word (icache or memory), pushes it
// downstream and hands it back to pc. Optional direct-mapped icache enabled by defining ICACHE_EN.
module inst_fetcher #(
    parameter int ICACHE_INDEX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic [31:0] in_pc,
    input  logic        in_pc_taken,
    input  logic        in_rollback,
    input  logic        in_queue_full,
    output logic        out_mem_req,
    output logic [31:0] out_mem_addr,
    input  logic        in_mem_ready,
    input  logic [31:0] in_mem_inst,
    output logic        out_fetcher_ena,
    output logic [31:0] out_last_pc,
    output logic [31:0] out_last_inst,
    output logic        out_issue_ena,
    output logic [31:0] out_issue_pc,
    output logic [31:0] out_issue_inst,
    output logic        out_issue_taken
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEM_WAIT,
        S_DISCARD,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_mem_req;
    logic [31:0] r_mem_addr;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic        r_taken;

    logic        w_start;
    logic        w_hit;
    logic [31:0] w_hit_inst;
    logic        w_load_req;
    logic        w_load_hit;
    logic        w_load_word;
    logic        w_pulse;

    assign w_start = ena & ~in_rollback & ~in_queue_full;

`ifdef ICACHE_EN
    localparam int LINES = 1 << ICACHE_INDEX_BITS;
    localparam int TAG_W = 30 - ICACHE_INDEX_BITS;

    logic [LINES-1:0]             r_valid;
    logic [TAG_W-1:0]             r_tag  [LINES];
    logic [31:0]                  r_data [LINES];
    logic [ICACHE_INDEX_BITS-1:0] w_rd_idx;
    logic [ICACHE_INDEX_BITS-1:0] w_wr_idx;
    logic                         w_fill;

    assign w_rd_idx   = in_pc[ICACHE_INDEX_BITS+1:2];
    assign w_wr_idx   = r_mem_addr[ICACHE_INDEX_BITS+1:2];
    // Words arriving for discarded fetches are still correct for their address, so they fill too.
    assign w_fill     = in_mem_ready & ((r_state == S_MEM_WAIT) | (r_state == S_DISCARD));
    assign w_hit      = r_valid[w_rd_idx] & (r_tag[w_rd_idx] == in_pc[31:ICACHE_INDEX_BITS+2]);
    assign w_hit_inst = r_data[w_rd_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (w_fill) begin
            r_valid[w_wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tag[w_wr_idx]  <= r_mem_addr[31:ICACHE_INDEX_BITS+2];
            r_data[w_wr_idx] <= in_mem_inst;
        end
    end
`else
    logic w_unused;

    assign w_hit      = 1'b0;
    assign w_hit_inst = '0;
    assign w_unused   = (ICACHE_INDEX_BITS != 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_load_req  = 1'b0;
        w_load_hit  = 1'b0;
        w_load_word = 1'b0;
        w_pulse     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    if (w_hit) begin
                        w_next     = S_DONE;
                        w_load_hit = 1'b1;
                    end else begin
                        w_next     = S_MEM_WAIT;
                        w_load_req = 1'b1;
                    end
                end
            end
            // Memory responses are taken even while ena is low so none is ever lost.
            S_MEM_WAIT: begin
                if (in_mem_ready) begin
                    w_next      = in_rollback ? S_IDLE : S_DONE;
                    w_load_word = ~in_rollback;
                end else if (in_rollback) begin
                    w_next = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (in_mem_ready) begin
                    w_next = S_IDLE;
                end
            end
            S_DONE: begin
                w_pulse = ena & ~in_rollback;
                if (in_rollback || ena) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_pc       <= '0;
            r_inst     <= '0;
            r_taken    <= 1'b0;
        end else begin
            r_mem_req <= (w_next == S_MEM_WAIT) || (w_next == S_DISCARD);
            if (w_load_req) begin
                r_mem_addr <= {in_pc[31:2], 2'b00};
            end
            if (w_load_req || w_load_hit) begin
                r_pc    <= in_pc;
                r_taken <= in_pc_taken;
            end
            if (w_load_hit) begin
                r_inst <= w_hit_inst;
            end else if (w_load_word) begin
                r_inst <= in_mem_inst;
            end
        end
    end

    assign out_mem_req     = r_mem_req;
    assign out_mem_addr    = r_mem_addr;
    assign out_fetcher_ena = w_pulse;
    assign out_issue_ena   = w_pulse;
    assign out_last_pc     = r_pc;
    assign out_last_inst   = r_inst;
    assign out_issue_pc    = r_pc;
    assign out_issue_inst  = r_inst;
    assign out_issue_taken = r_taken;

endmodule

// File: tb/tb_inst_fetcher.sv
// Scoreboard bench for inst_fetcher: a behavioural pc model queues the instruction it expects next,
// a memory responder answers requests, and a monitor checks every issue pulse against the queue.
module tb_inst_fetcher;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic [31:0] in_pc;
    logic        in_pc_taken;
    logic        in_rollback;
    logic        in_queue_full;
    logic        out_mem_req;
    logic [31:0] out_mem_addr;
    logic        in_mem_ready;
    logic [31:0] in_mem_inst;
    logic        out_fetcher_ena;
    logic [31:0] out_last_pc;
    logic [31:0] out_last_inst;
    logic        out_issue_ena;
    logic [31:0] out_issue_pc;
    logic [31:0] out_issue_inst;
    logic        out_issue_taken;

    always #5 clk = ~clk;

    inst_fetcher dut (
        .clk            (clk),
        .rst            (rst),
        .ena            (ena),
        .in_pc          (in_pc),
        .in_pc_taken    (in_pc_taken),
        .in_rollback    (in_rollback),
        .in_queue_full  (in_queue_full),
        .out_mem_req    (out_mem_req),
        .out_mem_addr   (out_mem_addr),
        .in_mem_ready   (in_mem_ready),
        .in_mem_inst    (in_mem_inst),
        .out_fetcher_ena(out_fetcher_ena),
        .out_last_pc    (out_last_pc),
        .out_last_inst  (out_last_inst),
        .out_issue_ena  (out_issue_ena),
        .out_issue_pc   (out_issue_pc),
        .out_issue_inst (out_issue_inst),
        .out_issue_taken(out_issue_taken)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        taken;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_issue = 0;
    int   fixed_lat = 2;
    int   cnt = -1;

    // Memory contents: an arbitrary fixed function of the word address.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return ({a[31:2], 2'b00} * 32'h9E3779B1) ^ 32'h00500093;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    task automatic push_cur();
        exp_t e;
        e.pc    = in_pc;
        e.inst  = word_at(in_pc);
        e.taken = in_pc_taken;
        exp_q.push_back(e);
    endtask

    // Behavioural pc: holds its PC until the fetcher delivers, then moves to pc+4 or a taken target.
    task automatic tick();
        logic pulse;
        logic rb;
        @(negedge clk);
        pulse = out_fetcher_ena;
        rb    = in_rollback;
        @(posedge clk);
        #2;
        in_rollback = 1'b0;
        if (pulse && !rb) begin
            in_pc       = in_pc_taken ? (32'($urandom_range(0, 127)) << 2) : in_pc + 32'd4;
            in_pc_taken = 1'($urandom_range(0, 1));
            push_cur();
        end
    endtask

    task automatic do_rollback(input logic [31:0] target);
        in_rollback = 1'b1;
        in_pc       = target;
        in_pc_taken = 1'($urandom_range(0, 1));
        exp_q.delete();
        push_cur();
        tick();
    endtask

    task automatic wait_req(input string name, input int budget);
        int k = 0;
        while (!out_mem_req && k < budget) begin
            tick();
            k++;
        end
        chk(name, {31'b0, out_mem_req}, 32'd1);
    endtask

    task automatic wait_issue(input string name, input int budget);
        int k = 0;
        int start = n_issue;
        while (n_issue == start && k < budget) begin
            tick();
            k++;
        end
        chk(name, n_issue, start + 1);
    endtask

    always @(negedge clk) begin
        if (!rst && (out_issue_ena || out_fetcher_ena)) begin
            n_issue++;
            chk("pulse_pair", {31'b0, out_fetcher_ena}, {31'b0, out_issue_ena});
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_issue: got pc 0x%08h, expected no issue", out_issue_pc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("issue_pc", out_issue_pc, mon_e.pc);
                chk("issue_inst", out_issue_inst, mon_e.inst);
                chk("issue_taken", {31'b0, out_issue_taken}, {31'b0, mon_e.taken});
                chk("last_pc", out_last_pc, mon_e.pc);
                chk("last_inst", out_last_inst, mon_e.inst);
            end
        end
    end

    // Memory controller: answers each request after a latency with a one-cycle ready pulse.
    initial begin
        in_mem_ready = 1'b0;
        in_mem_inst  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                in_mem_ready = 1'b0;
                cnt          = -1;
            end else if (in_mem_ready) begin
                in_mem_ready = 1'b0;
            end else if (out_mem_req) begin
                if (cnt < 0) begin
                    cnt = (fixed_lat >= 0) ? fixed_lat : $urandom_range(0, 4);
                    chk("addr_aligned", {30'b0, out_mem_addr[1:0]}, 32'd0);
                end
                if (cnt == 0) begin
                    in_mem_ready = 1'b1;
                    in_mem_inst  = word_at(out_mem_addr);
                    cnt          = -1;
                end else begin
                    cnt--;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int reqs;
        int start;
        rst           = 1'b1;
        ena           = 1'b1;
        in_pc         = 32'h0;
        in_pc_taken   = 1'b0;
        in_rollback   = 1'b0;
        in_queue_full = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_mem_req", {31'b0, out_mem_req}, 32'd0);
        chk("rst_mem_addr", out_mem_addr, 32'd0);
        chk("rst_fetcher_ena", {31'b0, out_fetcher_ena}, 32'd0);
        chk("rst_issue_ena", {31'b0, out_issue_ena}, 32'd0);
        chk("rst_issue_pc", out_issue_pc, 32'd0);
        chk("rst_issue_inst", out_issue_inst, 32'd0);
        chk("rst_last_pc", out_last_pc, 32'd0);
        chk("rst_last_inst", out_last_inst, 32'd0);
        chk("rst_issue_taken", {31'b0, out_issue_taken}, 32'd0);
        push_cur();
        rst = 1'b0;

        // Full queue blocks new fetches; releasing it starts one on the next edge.
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("qfull_no_req", {31'b0, out_mem_req}, 32'd0);
        end
        in_queue_full = 1'b0;
        tick();
        chk("req_after_qfull", {31'b0, out_mem_req}, 32'd1);
        chk("req_addr_0", out_mem_addr, 32'h0);
        wait_issue("issue_pc0", 20);
        tick();
        chk("req_right_after_done", {31'b0, out_mem_req}, 32'd1);
        chk("req_addr_4", out_mem_addr, 32'h4);
        wait_issue("issue_pc4", 20);

        // Rollback one cycle after a request: the word is dropped and the target fetched instead.
        fixed_lat = 3;
        do_rollback(32'h8);
        wait_req("req_pc8", 10);
        chk("req_addr_8", out_mem_addr, 32'h8);
        tick();
        do_rollback(32'h40);
        chk("discard_req_held", {31'b0, out_mem_req}, 32'd1);
        k = 0;
        while (!(out_mem_req && out_mem_addr == 32'h40) && k < 20) begin
            tick();
            k++;
        end
        chk("req_rollback_target", out_mem_addr, 32'h40);
        wait_issue("issue_pc40", 20);

        // Frozen stage still captures the memory word and issues it once released.
        wait_req("req_before_freeze", 10);
        ena = 1'b0;
        k = 0;
        while (!in_mem_ready && k < 20) begin
            tick();
            k++;
        end
        chk("ready_while_frozen", {31'b0, in_mem_ready}, 32'd1);
        start = n_issue;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("frozen_req_dropped", {31'b0, out_mem_req}, 32'd0);
            chk("frozen_no_issue", n_issue, start);
        end
        ena = 1'b1;
        tick();
        chk("unfreeze_issue", n_issue, start + 1);

        // Asynchronous reset while a request is outstanding.
        wait_req("req_before_rst", 10);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_async_req", {31'b0, out_mem_req}, 32'd0);
        chk("rst_async_addr", out_mem_addr, 32'd0);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        push_cur();
        wait_issue("issue_after_rst", 20);

`ifdef ICACHE_EN
        do_rollback(32'h10);
        wait_issue("issue_fill_10", 20);
        do_rollback(32'h10);
        reqs  = 0;
        start = n_issue;
        k     = 0;
        while (n_issue == start && k < 6) begin
            if (out_mem_req) reqs++;
            tick();
            k++;
        end
        chk("hit_no_req", reqs, 0);
        chk("hit_issued", n_issue, start + 1);
        do_rollback(32'h110);
        wait_req("req_alias_miss", 10);
        chk("req_alias_addr", out_mem_addr, 32'h110);
        wait_issue("issue_alias", 20);
`else
        reqs = 0;
`endif

        // Randomized traffic: stalls, full queue, variable latency and rollbacks.
        fixed_lat = -1;
        for (int i = 0; i < 3000; i++) begin
            ena           = ($urandom_range(0, 9) != 0);
            in_queue_full = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 24) == 0) begin
                do_rollback(32'($urandom_range(0, 127)) << 2);
            end else begin
                tick();
            end
        end
        ena           = 1'b1;
        in_queue_full = 1'b0;
        wait_issue("final_drain", 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
